// File: rtl/bridge_write_buffer_pkg.sv
// Shared definitions for the bridge write buffer: FSM encoding, window geometry, FIFO entry layout.
// No logic; types and constants only.
package bridge_write_buffer_pkg;

    localparam int WINDOW_W  = 26;
    localparam int WORD_AW   = WINDOW_W - 2;
    localparam int MEM_AW    = WORD_AW + 1;
    localparam int MEM_DW    = 16;
    localparam int ENTRY_W   = WORD_AW + 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_AW-1:0] word_addr;
        logic [31:0]        data;
    } entry_t;

endpackage

// File: rtl/bridge_write_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO; head is valid combinationally whenever not empty.
// Latency: a push is visible on head/level the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full (unless popping) or pop when empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 56
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bridge_write_buffer.sv
// Buffers 32-bit bridge writes and replays each as two 16-bit SDRAM writes (low halfword, then high).
// Latency: io_mem_wr rises 2 cycles after a push into an empty idle buffer; one word per 2 cycles sustained.
// Backpressure: io_mem_wait stalls the current halfword; writes arriving while full are dropped and flagged.
module bridge_write_buffer #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_bridge_wr,
    input  logic [31:0]            io_bridge_addr,
    input  logic [31:0]            io_bridge_dout,
    input  logic                   io_bridge_done,
    output logic                   io_mem_wr,
    output logic [24:0]            io_mem_addr,
    output logic [15:0]            io_mem_din,
    input  logic                   io_mem_wait,
    output logic                   io_done,
    output logic                   io_overflow,
    output logic [$clog2(DEPTH):0] io_level
);

    import bridge_write_buffer_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    state_t         state;
    state_t         state_nxt;
    entry_t         push_dat;
    entry_t         head_dat;
    logic           wr_vld;
    logic           push;
    logic           pop;
    logic           fifo_empty;
    logic           fifo_full;
    logic [LW-1:0]  level;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^io_bridge_addr[1:0];

    // Writes outside the 64 MiB window, or during reset, never reach the FIFO.
    assign wr_vld = io_bridge_wr && !reset &&
                    (io_bridge_addr[31:WINDOW_W] == BASE_ADDR[31:WINDOW_W]);

    assign pop  = (state == ST_HIGH) && !io_mem_wait;
    assign push = wr_vld && (!fifo_full || pop);

    assign push_dat.word_addr = io_bridge_addr[WINDOW_W-1:2];
    assign push_dat.data      = io_bridge_dout;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_dat),
        .pop       (pop),
        .head      (head_dat),
        .level     (level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign io_level = level;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nxt = ST_LOW;
            end
            ST_LOW: begin
                if (!io_mem_wait) state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                // A same-cycle push counts so back-to-back entries skip the IDLE bubble.
                if (!io_mem_wait) begin
                    if ((level > LW'(1)) || push) state_nxt = ST_LOW;
                    else                          state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        io_mem_wr   = 1'b0;
        io_mem_addr = '0;
        io_mem_din  = '0;
        case (state)
            ST_LOW: begin
                io_mem_wr   = 1'b1;
                io_mem_addr = {head_dat.word_addr, 1'b0};
                io_mem_din  = head_dat.data[15:0];
            end
            ST_HIGH: begin
                io_mem_wr   = 1'b1;
                io_mem_addr = {head_dat.word_addr, 1'b1};
                io_mem_din  = head_dat.data[31:16];
            end
            default: begin
                io_mem_wr   = 1'b0;
                io_mem_addr = '0;
                io_mem_din  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_overflow <= 1'b0;
            io_done     <= 1'b0;
        end else begin
            if (wr_vld && fifo_full && !pop) io_overflow <= 1'b1;
            io_done <= io_bridge_done && fifo_empty && (state == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_bridge_write_buffer.sv
// Self-checking bench for bridge_write_buffer: vector table plus hand sequences, halfword scoreboard.
module tb_bridge_write_buffer;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_bridge_wr;
    logic [31:0] io_bridge_addr;
    logic [31:0] io_bridge_dout;
    logic        io_bridge_done;
    logic        io_mem_wr;
    logic [24:0] io_mem_addr;
    logic [15:0] io_mem_din;
    logic        io_mem_wait;
    logic        io_done;
    logic        io_overflow;
    logic [4:0]  io_level;

    always #5 clock = ~clock;

    bridge_write_buffer #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_bridge_wr   (io_bridge_wr),
        .io_bridge_addr (io_bridge_addr),
        .io_bridge_dout (io_bridge_dout),
        .io_bridge_done (io_bridge_done),
        .io_mem_wr      (io_mem_wr),
        .io_mem_addr    (io_mem_addr),
        .io_mem_din     (io_mem_din),
        .io_mem_wait    (io_mem_wait),
        .io_done        (io_done),
        .io_overflow    (io_overflow),
        .io_level       (io_level)
    );

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] din;
    } hw_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        accept;
    } vec_t;

    hw_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_taken = 0;

    logic        prev_stall = 1'b0;
    logic [24:0] prev_addr;
    logic [15:0] prev_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    // Expected halfwords for one accepted bridge write: low first, then high.
    task automatic expect_word(input logic [31:0] addr, input logic [31:0] data);
        hw_t h;
        h.addr = {addr[25:2], 1'b0};
        h.din  = data[15:0];
        sb.push_back(h);
        h.addr = {addr[25:2], 1'b1};
        h.din  = data[31:16];
        sb.push_back(h);
    endtask

    always @(negedge clock) begin
        if (!reset && io_mem_wr) begin
            if (prev_stall) begin
                check("stall_addr_stable", 32'(io_mem_addr), 32'(prev_addr));
                check("stall_din_stable", 32'(io_mem_din), 32'(prev_din));
            end
            if (!io_mem_wait) begin
                n_taken++;
                if (sb.size() == 0) begin
                    check("unexpected_mem_write", 32'(io_mem_addr), 32'h0);
                    check("unexpected_mem_write_flag", 32'd1, 32'd0);
                end else begin
                    hw_t e;
                    e = sb.pop_front();
                    check("mem_addr", 32'(io_mem_addr), 32'(e.addr));
                    check("mem_din", 32'(io_mem_din), 32'(e.din));
                end
            end
            prev_stall = io_mem_wait;
            prev_addr  = io_mem_addr;
            prev_din   = io_mem_din;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vecs[6];

    initial begin
        int t0;

        reset          = 1'b1;
        io_bridge_wr   = 1'b0;
        io_bridge_addr = '0;
        io_bridge_dout = '0;
        io_bridge_done = 1'b0;
        io_mem_wait    = 1'b0;

        vecs[0] = '{addr: 32'h0000_0010, data: 32'hDEAD_BEEF, accept: 1'b1};
        vecs[1] = '{addr: 32'h0400_0000, data: 32'h1111_2222, accept: 1'b0};
        vecs[2] = '{addr: 32'h03FF_FFFC, data: 32'h1234_5678, accept: 1'b1};
        vecs[3] = '{addr: 32'hFC00_0000, data: 32'h3333_4444, accept: 1'b0};
        vecs[4] = '{addr: 32'h0000_0003, data: 32'hCAFE_F00D, accept: 1'b1};
        vecs[5] = '{addr: 32'h0200_0008, data: 32'h0BAD_C0DE, accept: 1'b1};

        repeat (2) drive_edge();
        sample();
        check("rst_mem_wr", 32'(io_mem_wr), 32'd0);
        check("rst_mem_addr", 32'(io_mem_addr), 32'd0);
        check("rst_mem_din", 32'(io_mem_din), 32'd0);
        check("rst_level", 32'(io_level), 32'd0);
        check("rst_done", 32'(io_done), 32'd0);
        check("rst_overflow", 32'(io_overflow), 32'd0);
        drive_edge();
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive_edge();
            io_bridge_wr   = 1'b1;
            io_bridge_addr = vecs[i].addr;
            io_bridge_dout = vecs[i].data;
            if (vecs[i].accept) expect_word(vecs[i].addr, vecs[i].data);
            drive_edge();
            io_bridge_wr = 1'b0;
            sample();
            check("vec_level_after_wr", 32'(io_level), 32'(vecs[i].accept));
            repeat (6) sample();
            check("vec_drained", sb.size(), 32'd0);
            check("vec_level_idle", 32'(io_level), 32'd0);
        end

        // First request rises exactly two cycles after the strobe cycle.
        drive_edge();
        io_bridge_wr   = 1'b1;
        io_bridge_addr = 32'h0000_0010;
        io_bridge_dout = 32'hDEAD_BEEF;
        expect_word(32'h0000_0010, 32'hDEAD_BEEF);
        sample();
        check("rise_cycle0", 32'(io_mem_wr), 32'd0);
        drive_edge();
        io_bridge_wr = 1'b0;
        sample();
        check("rise_cycle1", 32'(io_mem_wr), 32'd0);
        sample();
        check("rise_cycle2", 32'(io_mem_wr), 32'd1);
        check("rise_cycle2_addr", 32'(io_mem_addr), 32'h8);
        repeat (4) sample();
        check("rise_drained", sb.size(), 32'd0);

        // Toggling stall: order and stability across every stalled cycle.
        t0 = n_taken;
        io_mem_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_edge();
            io_bridge_wr   = 1'b1;
            io_bridge_addr = 32'h0000_0100 + 32'(i * 4);
            io_bridge_dout = 32'h5A00_0000 + 32'(i * 32'h0001_0101);
            io_mem_wait    = ~io_mem_wait;
            expect_word(io_bridge_addr, io_bridge_dout);
        end
        drive_edge();
        io_bridge_wr = 1'b0;
        io_mem_wait  = ~io_mem_wait;
        for (int k = 0; k < 60; k++) begin
            drive_edge();
            io_mem_wait = ~io_mem_wait;
            if (sb.size() == 0) break;
        end
        io_mem_wait = 1'b0;
        repeat (3) sample();
        check("toggle_drained", sb.size(), 32'd0);
        check("toggle_count", 32'(n_taken - t0), 32'd8);
        check("toggle_level", 32'(io_level), 32'd0);

        // io_done held off until the last entry's high halfword is taken.
        io_mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            io_bridge_wr   = 1'b1;
            io_bridge_addr = 32'h0000_0400 + 32'(i * 4);
            io_bridge_dout = 32'h7700_0000 + 32'(i);
            expect_word(io_bridge_addr, io_bridge_dout);
        end
        drive_edge();
        io_bridge_wr   = 1'b0;
        io_bridge_done = 1'b1;
        sample();
        check("done_pending", 32'(io_done), 32'd0);
        drive_edge();
        io_mem_wait = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (sb.size() == 0) break;
            check("done_draining", 32'(io_done), 32'd0);
        end
        check("done_drain_bound", sb.size(), 32'd0);
        sample();
        check("done_idle_entry", 32'(io_done), 32'd0);
        sample();
        check("done_asserted", 32'(io_done), 32'd1);
        drive_edge();
        io_bridge_done = 1'b0;
        sample();
        sample();
        check("done_deasserted", 32'(io_done), 32'd0);

        // Overflow: 17 writes while stalled; the 17th must be dropped.
        t0 = n_taken;
        io_mem_wait = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_edge();
            io_bridge_wr   = 1'b1;
            io_bridge_addr = 32'h0000_0200 + 32'(i * 4);
            io_bridge_dout = 32'hA500_0000 + 32'(i);
            if (i < 16) expect_word(io_bridge_addr, io_bridge_dout);
        end
        drive_edge();
        io_bridge_wr = 1'b0;
        sample();
        check("ovf_level_full", 32'(io_level), 32'd16);
        check("ovf_flag", 32'(io_overflow), 32'd1);
        drive_edge();
        io_mem_wait = 1'b0;
        for (int k = 0; k < 80; k++) begin
            sample();
            if (sb.size() == 0) break;
        end
        repeat (4) sample();
        check("ovf_drained", sb.size(), 32'd0);
        check("ovf_take_count", 32'(n_taken - t0), 32'd32);
        check("ovf_level_empty", 32'(io_level), 32'd0);
        check("ovf_sticky", 32'(io_overflow), 32'd1);

        // Reset while in HIGH with 5 entries queued.
        io_mem_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_edge();
            io_bridge_wr   = 1'b1;
            io_bridge_addr = 32'h0000_0800 + 32'(i * 4);
            io_bridge_dout = 32'h3C00_0000 + 32'(i);
            expect_word(io_bridge_addr, io_bridge_dout);
        end
        drive_edge();
        io_bridge_wr = 1'b0;
        io_mem_wait  = 1'b0;
        drive_edge();
        io_mem_wait    = 1'b1;
        reset          = 1'b1;
        io_bridge_done = 1'b1;
        io_bridge_wr   = 1'b1;
        io_bridge_addr = 32'h0000_0040;
        io_bridge_dout = 32'hFFFF_0000;
        sample();
        check("rst_mid_in_high", 32'(io_mem_addr[0]), 32'd1);
        check("rst_mid_level_pre", 32'(io_level), 32'd5);
        sample();
        check("rst_mid_mem_wr", 32'(io_mem_wr), 32'd0);
        check("rst_mid_level", 32'(io_level), 32'd0);
        check("rst_mid_overflow", 32'(io_overflow), 32'd0);
        check("rst_mid_done", 32'(io_done), 32'd0);
        sb.delete();
        drive_edge();
        reset          = 1'b0;
        io_bridge_wr   = 1'b0;
        io_bridge_done = 1'b0;
        io_mem_wait    = 1'b0;
        sample();
        check("rst_wr_ignored", 32'(io_level), 32'd0);
        repeat (4) sample();
        check("rst_no_traffic", 32'(io_mem_wr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_write_buffer.md
BRIDGE_WRITE_BUFFER -- requirements
Module: bridge_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, base of the accepted 64 MiB bridge window.
REQ-003 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port io_bridge_wr  input  1  one-cycle bridge write strobe.
REQ-006 SHALL have port io_bridge_addr  input  32  bridge byte address.
REQ-007 SHALL have port io_bridge_dout  input  32  bridge write data, little-endian.
REQ-008 SHALL have port io_bridge_done  input  1  host reports all data-slot transfers complete (level).
REQ-009 SHALL have port io_mem_wr  output  1  memory write request.
REQ-010 SHALL have port io_mem_addr  output  25  SDRAM 16-bit word address.
REQ-011 SHALL have port io_mem_din  output  16  SDRAM write data.
REQ-012 SHALL have port io_mem_wait  input  1  memory stall; a request is taken in a cycle with io_mem_wr=1 and io_mem_wait=0.
REQ-013 SHALL have port io_done  output  1  load finished and buffer drained.
REQ-014 SHALL have port io_overflow  output  1  sticky overflow flag.
REQ-015 SHALL have port io_level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 SHALL treat all inputs as synchronous to clock; CDC lives outside this block.

Function
REQ-017 SHALL accept a write only when io_bridge_wr=1 and io_bridge_addr[31:26]==BASE_ADDR[31:26]; all other writes are ignored with no side effect.
REQ-018 SHALL push {io_bridge_addr[25:2], io_bridge_dout} into the FIFO on an accepted write.
REQ-019 SHALL push when io_level<DEPTH, or when io_level==DEPTH and a pop occurs in the same cycle.
REQ-020 SHALL drop the write and set io_overflow when full with no same-cycle pop; io_overflow stays set until reset.
REQ-021 SHALL run an FSM IDLE -> LOW -> HIGH -> (LOW if FIFO non-empty, else IDLE).
REQ-022 SHALL go IDLE->LOW when the FIFO is non-empty; io_mem_wr rises 2 cycles after the push cycle into an empty idle buffer.
REQ-023 In LOW SHALL drive io_mem_wr=1, io_mem_addr={word_addr,1'b0}, io_mem_din=data[15:0], and move to HIGH in the cycle the request is taken.
REQ-024 In HIGH SHALL drive io_mem_wr=1, io_mem_addr={word_addr,1'b1}, io_mem_din=data[31:16], and pop the FIFO head in the cycle the request is taken.
REQ-025 SHALL hold io_mem_addr/io_mem_din stable while io_mem_wr=1 and io_mem_wait=1.
REQ-026 SHALL drive io_mem_wr=0 in IDLE; io_mem_addr/io_mem_din are don't-care there.
REQ-027 SHALL sustain one 32-bit word per 2 cycles when io_mem_wait=0, with no IDLE bubble between back-to-back entries.
REQ-028 SHALL register io_done as io_bridge_done & FIFO empty & state IDLE, one cycle latency; it falls the cycle after any term goes false.
REQ-029 SHALL update io_level on the edge of each push/pop; a simultaneous push and pop leaves it unchanged.

Reset
REQ-030 On reset SHALL give state=IDLE, FIFO empty, io_level=0, io_mem_wr=0, io_mem_addr=0, io_mem_din=0, io_done=0, io_overflow=0.
REQ-031 Reset mid-transfer SHALL abandon the in-flight halfword and discard FIFO contents; io_mem_wr=0 the cycle after reset is sampled.
REQ-032 SHALL ignore io_bridge_wr in any cycle in which reset=1.

Structure
REQ-033 SHALL place FSM state encoding and the window width (26) in the shared core package.
REQ-034 SHALL implement the storage as one sub-module, sync_fifo (DEPTH x 56 bits, inferred RAM or registers, show-ahead read).

Verification
REQ-035 Single write addr=0x0000_0010 data=0xDEAD_BEEF, wait=0 -> mem writes (0x000008,0xBEEF) then (0x000009,0xDEAD); io_mem_wr rises 2 cycles after the strobe.
REQ-036 Write addr=0x0400_0000 with BASE_ADDR=0 -> no push, io_level stays 0, no mem request.
REQ-037 17 back-to-back writes with io_mem_wait=1 held -> io_level=16, io_overflow=1, 17th data never appears on io_mem_din.
REQ-038 4 writes, io_mem_wait toggling 1/0 every cycle -> 8 halfword writes in order, addr/data stable during every stall.
REQ-039 io_bridge_done=1 while 3 entries remain -> io_done=0 until the last HIGH is taken, then 1 one cycle after IDLE.
REQ-040 Reset asserted in HIGH with 5 entries queued -> next cycle io_mem_wr=0, io_level=0, io_overflow=0, io_done=0.
